// File: rtl/bwzz_pkg.sv
// Shared types and constants for the BWZZ pipeline hazard/interrupt control.
package bwzz_pkg;

  // Scoreboard destination field is wider than any supported register address.
  localparam int unsigned SB_ADDR_W   = 16;
  localparam int unsigned FWD_REGFILE = 0;
  localparam int unsigned FWD_EX      = 1;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] dst;
    logic                 reg_write;
    logic                 mem_read;
  } sb_entry_t;

  typedef enum logic [1:0] {IDLE, DRAIN, SAVE, VECTOR} int_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle between the ID stage and hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned FWD_SEL_W  = 2
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src_addr;
  logic [REG_ADDR_W-1:0] id_dst_addr;
  logic                  id_src_used;
  logic                  id_dst_used;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  branch_taken;
  logic                  int_req;
  logic                  stall;
  logic                  flush_if_id;
  logic                  flush_id_ex;
  logic [FWD_SEL_W-1:0]  fwd_sel_src;
  logic [FWD_SEL_W-1:0]  fwd_sel_dst;
  logic                  int_save;
  logic                  int_ack;
  logic                  int_busy;

  modport master (
    output id_valid, id_src_addr, id_dst_addr, id_src_used, id_dst_used,
           id_reg_write, id_mem_read, branch_taken, int_req,
    input  stall, flush_if_id, flush_id_ex, fwd_sel_src, fwd_sel_dst,
           int_save, int_ack, int_busy
  );

  modport slave (
    input  id_valid, id_src_addr, id_dst_addr, id_src_used, id_dst_used,
           id_reg_write, id_mem_read, branch_taken, int_req,
    output stall, flush_if_id, flush_id_ex, fwd_sel_src, fwd_sel_dst,
           int_save, int_ack, int_busy
  );
endinterface

// File: rtl/hazard_match.sv
// Nearest-stage priority encoder for one ID operand against the scoreboard.
// HAZARD_FWD_EN: defined -> forward and stall on load-use only; undefined -> full interlock.
module hazard_match
  import bwzz_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned FWD_SEL_W  = $clog2(NUM_STAGES + 1)
) (
  input  sb_entry_t [NUM_STAGES:1] sb_i,
  input  logic [SB_ADDR_W-1:0]     addr_i,
  input  logic                     used_i,
  input  logic                     id_valid_i,
  output logic [FWD_SEL_W-1:0]     fwd_sel_o,
  output logic                     stall_hit_o
);

  logic [FWD_SEL_W-1:0] near_k;
  logic                 near_mr;
  logic                 any_hit;
  logic                 load_hit;

  // Scan oldest to youngest so the nearest match overwrites the rest.
  always_comb begin
    near_k  = FWD_SEL_W'(FWD_REGFILE);
    near_mr = 1'b0;
    any_hit = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (id_valid_i && used_i && sb_i[k].valid && sb_i[k].reg_write &&
          (sb_i[k].dst == addr_i)) begin
        near_k  = FWD_SEL_W'(k);
        near_mr = sb_i[k].mem_read;
        any_hit = 1'b1;
      end
    end
  end

  assign load_hit = (near_k == FWD_SEL_W'(FWD_EX)) && near_mr;

`ifdef HAZARD_FWD_EN
  assign fwd_sel_o   = near_k;
  assign stall_hit_o = load_hit;
`else
  // load_hit is a subset of any_hit; both builds share the same encoder.
  assign fwd_sel_o   = '0;
  assign stall_hit_o = any_hit | load_hit;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and interrupt-sequencing controller beside the ID stage.
// HAZARD_FWD_EN selects forwarding (defined) or full interlock (undefined).
module hazard_ctrl
  import bwzz_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned FWD_SEL_W  = $clog2(NUM_STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus_io
);

  sb_entry_t [NUM_STAGES:1] sb_q, sb_d;
  int_state_t               state_q, state_d;

  logic [SB_ADDR_W-1:0] src_ext, dst_ext;
  logic                 src_hit, dst_hit;
  logic                 drain_busy;
  logic                 stall, flush_if_id, flush_id_ex, int_save, int_ack;

  assign src_ext = {{(SB_ADDR_W - REG_ADDR_W){1'b0}}, bus_io.id_src_addr};
  assign dst_ext = {{(SB_ADDR_W - REG_ADDR_W){1'b0}}, bus_io.id_dst_addr};

  hazard_match #(.NUM_STAGES(NUM_STAGES), .FWD_SEL_W(FWD_SEL_W)) u_match_src (
    .sb_i        (sb_q),
    .addr_i      (src_ext),
    .used_i      (bus_io.id_src_used),
    .id_valid_i  (bus_io.id_valid),
    .fwd_sel_o   (bus_io.fwd_sel_src),
    .stall_hit_o (src_hit)
  );

  hazard_match #(.NUM_STAGES(NUM_STAGES), .FWD_SEL_W(FWD_SEL_W)) u_match_dst (
    .sb_i        (sb_q),
    .addr_i      (dst_ext),
    .used_i      (bus_io.id_dst_used),
    .id_valid_i  (bus_io.id_valid),
    .fwd_sel_o   (bus_io.fwd_sel_dst),
    .stall_hit_o (dst_hit)
  );

  // Last stage retires this cycle, so only the younger ones keep DRAIN alive.
  always_comb begin
    drain_busy = 1'b0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      if (sb_q[k].valid) drain_busy = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    int_save    = 1'b0;
    int_ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_io.branch_taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (src_hit || dst_hit) begin
          stall       = 1'b1;
          flush_id_ex = 1'b1;
        end
        if (bus_io.int_req && !bus_io.branch_taken) state_d = DRAIN;
      end
      DRAIN: begin
        stall       = 1'b1;
        flush_id_ex = 1'b1;
        flush_if_id = bus_io.branch_taken;
        if (!drain_busy) state_d = SAVE;
      end
      SAVE: begin
        stall    = 1'b1;
        int_save = 1'b1;
        state_d  = VECTOR;
      end
      VECTOR: begin
        int_ack     = 1'b1;
        flush_if_id = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sb_d = '0;
    if (bus_io.id_valid && !stall && !flush_id_ex) begin
      sb_d[1].valid     = 1'b1;
      sb_d[1].dst       = dst_ext;
      sb_d[1].reg_write = bus_io.id_reg_write;
      sb_d[1].mem_read  = bus_io.id_mem_read;
    end
    for (int k = 2; k <= NUM_STAGES; k++) sb_d[k] = sb_q[k-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q    <= '0;
      state_q <= IDLE;
    end else begin
      sb_q    <= sb_d;
      state_q <= state_d;
    end
  end

  assign bus_io.stall       = stall;
  assign bus_io.flush_if_id = flush_if_id;
  assign bus_io.flush_id_ex = flush_id_ex;
  assign bus_io.int_save    = int_save;
  assign bus_io.int_ack     = int_ack;
  assign bus_io.int_busy    = (state_q != IDLE);

endmodule
